// File: rtl/bus_sram_pkg.sv
// Shared encodings for the bus-to-SRAM controller.
package bus_sram_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/bus_sram_ctl_if.sv
// SPI-slave strobe/address side and SRAM control side of the controller.
interface bus_sram_ctl_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [ADDR_W-1:0] address_bus;
  logic              read_n;
  logic              write_n;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              busy;
  logic              err;

  modport master (
    output address_bus, read_n, write_n,
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, busy, err
  );

  modport slave (
    input  address_bus, read_n, write_n,
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, busy, err
  );
endinterface

// File: rtl/bus_sram_ctl_sync_fall.sv
// Two-flop synchroniser for an active-low async strobe with a registered
// one-clock pulse on each synchronised high-to-low transition.
module sync_fall (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic fall
);
  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      fall <= s2 & ~s1;
    end
  end

  assign q = s2;
endmodule

// File: rtl/bus_sram_ctl.sv
// Bus-to-SRAM controller: turns synchronised SPI-slave strobes into timed
// SETUP/ACCESS/HOLD cycles on an async SRAM and returns read data.
module bus_sram_ctl
  import bus_sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  bus_sram_ctl_if.slave     ctl,
  inout  wire  [DATA_W-1:0] data_bus,
  inout  wire  [DATA_W-1:0] sram_data
);
  logic rd_q, rd_fall, wr_q, wr_fall;

  sync_fall u_sync_rd (.clk(clk), .reset(reset), .d(ctl.read_n),  .q(rd_q), .fall(rd_fall));
  sync_fall u_sync_wr (.clk(clk), .reset(reset), .d(ctl.write_n), .q(wr_q), .fall(wr_fall));

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  op_t                 cur_op;
  logic [DATA_W-1:0]   cur_data;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_drive;
  logic                pend_valid;
  op_t                 pend_op;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_data;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic                ce_n_q, oe_n_q, we_n_q, busy_q, err_q;

  // Both strobes low when one is detected is illegal and runs nothing.
  logic clash_c, req_c;
  op_t  req_op_c;
  assign clash_c  = (rd_fall | wr_fall) & ~rd_q & ~wr_q;
  assign req_c    = (rd_fall | wr_fall) & ~clash_c;
  assign req_op_c = wr_fall ? OP_WRITE : OP_READ;

  op_t               start_op_c;
  logic [ADDR_W-1:0] start_addr_c;
  logic [DATA_W-1:0] start_data_c;
  assign start_op_c   = pend_valid ? pend_op   : req_op_c;
  assign start_addr_c = pend_valid ? pend_addr : ctl.address_bus;
  assign start_data_c = pend_valid ? pend_data : data_bus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_op      <= OP_READ;
      cur_data    <= '0;
      rd_data     <= '0;
      wr_drive    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_op     <= OP_READ;
      pend_addr   <= '0;
      pend_data   <= '0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (clash_c) err_q <= 1'b1;

      // A request that cannot start this clock parks here; the newest one wins.
      if (req_c && (state != IDLE || pend_valid)) begin
        pend_valid <= 1'b1;
        pend_op    <= req_op_c;
        pend_addr  <= ctl.address_bus;
        pend_data  <= data_bus;
      end else if (state == IDLE && pend_valid) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pend_valid || req_c) begin
            state       <= SETUP;
            cur_op      <= start_op_c;
            sram_addr_q <= start_addr_c;
            cur_data    <= start_data_c;
            wr_drive    <= (start_op_c == OP_WRITE);
            ce_n_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SETUP: begin
          state  <= ACCESS;
          cnt    <= WAIT_W'(WAIT_CYCLES - 1);
          oe_n_q <= (cur_op == OP_WRITE);
          we_n_q <= (cur_op == OP_READ);
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= HOLD;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            if (cur_op == OP_READ) rd_data <= sram_data;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        HOLD: begin
          state    <= IDLE;
          ce_n_q   <= 1'b1;
          wr_drive <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.sram_addr = sram_addr_q;
  assign ctl.sram_ce_n = ce_n_q;
  assign ctl.sram_oe_n = oe_n_q;
  assign ctl.sram_we_n = we_n_q;
  assign ctl.busy      = busy_q;
  assign ctl.err       = err_q;

  // Read data follows the raw strobes so the slave sees it as soon as it turns the bus.
  assign data_bus  = (!reset && !ctl.read_n && ctl.write_n) ? rd_data : {DATA_W{1'bz}};
  assign sram_data = wr_drive ? cur_data : {DATA_W{1'bz}};
endmodule

// File: tb/tb_bus_sram_ctl.sv
// Self-checking bench for bus_sram_ctl: WAIT_CYCLES=2 and WAIT_CYCLES=1 instances
// against behavioural SRAM models and an expected-memory reference.
module tb_bus_sram_ctl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst     = 2'b11;
  logic [1:0] rn      = 2'b11;
  logic [1:0] wn      = 2'b11;
  logic [6:0] tb_addr = '0;
  logic [7:0] tb_data = '0;
  logic       tb_drv  = 1'b0;

  // Undriven buses float to a known level so high-Z is observable.
  tri1 [7:0] db0;
  tri0 [7:0] db1;
  tri1 [7:0] sd0;
  tri1 [7:0] sd1;

  bus_sram_ctl_if bif0 ();
  bus_sram_ctl_if bif1 ();

  assign bif0.address_bus = tb_addr;
  assign bif0.read_n      = rn[0];
  assign bif0.write_n     = wn[0];
  assign bif1.address_bus = tb_addr;
  assign bif1.read_n      = rn[1];
  assign bif1.write_n     = wn[1];
  assign db0 = tb_drv ? tb_data : 8'bz;
  assign db1 = tb_drv ? tb_data : 8'bz;

  bus_sram_ctl #(.ADDR_W(7), .DATA_W(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(rst[0]), .ctl(bif0), .data_bus(db0), .sram_data(sd0));
  bus_sram_ctl #(.ADDR_W(7), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst[1]), .ctl(bif1), .data_bus(db1), .sram_data(sd1));

  // Async SRAM models: level-sensitive write, output enabled by ce/oe with we high.
  logic [7:0] mem0 [128];
  logic [7:0] mem1 [128];
  assign sd0 = (!bif0.sram_ce_n && !bif0.sram_oe_n && bif0.sram_we_n) ? mem0[bif0.sram_addr] : 8'bz;
  assign sd1 = (!bif1.sram_ce_n && !bif1.sram_oe_n && bif1.sram_we_n) ? mem1[bif1.sram_addr] : 8'bz;

  logic [1:0] busy_v;
  assign busy_v = {bif1.busy, bif0.busy};

  int         we_cnt [2];
  int         oe_cnt [2];
  int         ce_cnt [2];
  int         busy_cnt [2];
  logic       prev_we0 = 1'b1;
  logic [6:0] commit_q [$];

  always @(negedge clk) begin
    if (!bif0.sram_ce_n && !bif0.sram_we_n) mem0[bif0.sram_addr] <= sd0;
    if (!bif1.sram_ce_n && !bif1.sram_we_n) mem1[bif1.sram_addr] <= sd1;
    if (!bif0.sram_we_n) we_cnt[0]   <= we_cnt[0] + 1;
    if (!bif0.sram_oe_n) oe_cnt[0]   <= oe_cnt[0] + 1;
    if (!bif0.sram_ce_n) ce_cnt[0]   <= ce_cnt[0] + 1;
    if (bif0.busy)       busy_cnt[0] <= busy_cnt[0] + 1;
    if (!bif1.sram_we_n) we_cnt[1]   <= we_cnt[1] + 1;
    if (!bif1.sram_oe_n) oe_cnt[1]   <= oe_cnt[1] + 1;
    if (!bif1.sram_ce_n) ce_cnt[1]   <= ce_cnt[1] + 1;
    if (bif1.busy)       busy_cnt[1] <= busy_cnt[1] + 1;
    if (!prev_we0 && bif0.sram_we_n) commit_q.push_back(bif0.sram_addr);
    prev_we0 <= bif0.sram_we_n;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One strobe transaction held long enough for the whole cycle to finish.
  task automatic do_op(input int d, input bit wr, input logic [6:0] a, input logic [7:0] dv,
                       output logic [7:0] rdv, output logic [7:0] zv,
                       output int we_c, output int oe_c, output int busy_c);
    int w, b_we, b_oe, b_busy, guard;
    w = (d == 0) ? 2 : 1;
    @(negedge clk);
    b_we = we_cnt[d]; b_oe = oe_cnt[d]; b_busy = busy_cnt[d];
    tb_addr = a; tb_data = dv; tb_drv = wr;
    if (wr) wn[d] = 1'b0; else rn[d] = 1'b0;
    repeat (w + 5) @(negedge clk);
    rdv = (d == 0) ? db0 : db1;
    rn[d] = 1'b1; wn[d] = 1'b1; tb_drv = 1'b0;
    #1 zv = (d == 0) ? db0 : db1;
    guard = 0;
    while (busy_v[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("busy_timeout", 32'(guard < 20), 32'd1);
    repeat (3) @(negedge clk);
    we_c = we_cnt[d] - b_we; oe_c = oe_cnt[d] - b_oe; busy_c = busy_cnt[d] - b_busy;
  endtask

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    int         exp_we;
    int         exp_oe;
    int         exp_busy;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] ref_mem [128];
  bit         ref_valid [128];

  initial begin
    logic [7:0] rdv, zv;
    int we_c, oe_c, busy_c;
    int b_ce, b_we, b_oe, b_busy, base;
    bit bh [16];
    int n_hi, runs, gap, last_hi;

    vecs[0] = '{1'b1, 7'h12, 8'hA5, 8'h00, 2, 0, 4};
    vecs[1] = '{1'b0, 7'h12, 8'h00, 8'hA5, 0, 2, 4};
    vecs[2] = '{1'b1, 7'h00, 8'h00, 8'h00, 2, 0, 4};
    vecs[3] = '{1'b0, 7'h00, 8'h00, 8'h00, 0, 2, 4};
    vecs[4] = '{1'b1, 7'h7F, 8'h5A, 8'h00, 2, 0, 4};
    vecs[5] = '{1'b0, 7'h7F, 8'h00, 8'h5A, 0, 2, 4};
    vecs[6] = '{1'b1, 7'h12, 8'hC3, 8'h00, 2, 0, 4};
    vecs[7] = '{1'b0, 7'h12, 8'h00, 8'hC3, 0, 2, 4};
    vecs[8] = '{1'b0, 7'h00, 8'h00, 8'h00, 0, 2, 4};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ce_n", 32'(bif0.sram_ce_n), 32'd1);
    check("rst_oe_n", 32'(bif0.sram_oe_n), 32'd1);
    check("rst_we_n", 32'(bif0.sram_we_n), 32'd1);
    check("rst_addr", 32'(bif0.sram_addr), 32'd0);
    check("rst_busy", 32'(bif0.busy), 32'd0);
    check("rst_err",  32'(bif0.err), 32'd0);
    check("rst_db_z", 32'(db0), 32'hFF);
    check("rst_sd_z", 32'(sd0), 32'hFF);
    check("rst_ce_n_w1", 32'(bif1.sram_ce_n), 32'd1);
    rst = 2'b00;
    repeat (3) @(negedge clk);

    // Directed vectors on the WAIT_CYCLES=2 instance
    for (int i = 0; i < 9; i++) begin
      do_op(0, vecs[i].wr, vecs[i].addr, vecs[i].data, rdv, zv, we_c, oe_c, busy_c);
      check($sformatf("vec%0d_we_len", i), 32'(we_c), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_oe_len", i), 32'(oe_c), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d_busy_len", i), 32'(busy_c), 32'(vecs[i].exp_busy));
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_sram", i), 32'(mem0[vecs[i].addr]), 32'(vecs[i].data));
      end else begin
        check($sformatf("vec%0d_rd", i), 32'(rdv), 32'(vecs[i].exp_rd));
        check($sformatf("vec%0d_db_z", i), 32'(zv), 32'hFF);
      end
    end

    // Randomised traffic against an expected-memory model
    for (int i = 0; i < 24; i++) begin
      logic [6:0] a;
      logic [7:0] dv;
      bit         wr;
      a  = 7'(32 + $urandom_range(0, 15));
      dv = 8'($urandom);
      wr = !ref_valid[a] || ($urandom_range(0, 1) == 1);
      do_op(0, wr, a, dv, rdv, zv, we_c, oe_c, busy_c);
      check($sformatf("rnd%0d_we_len", i), 32'(we_c), wr ? 32'd2 : 32'd0);
      check($sformatf("rnd%0d_oe_len", i), 32'(oe_c), wr ? 32'd0 : 32'd2);
      check($sformatf("rnd%0d_busy_len", i), 32'(busy_c), 32'd4);
      if (wr) begin
        ref_mem[a]   = dv;
        ref_valid[a] = 1'b1;
      end else begin
        check($sformatf("rnd%0d_rd", i), 32'(rdv), 32'(ref_mem[a]));
      end
    end

    // Simultaneous strobes: nothing runs, err is sticky until reset
    @(negedge clk);
    b_ce = ce_cnt[0]; b_we = we_cnt[0]; b_oe = oe_cnt[0]; b_busy = busy_cnt[0];
    rn[0] = 1'b0; wn[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("both_db_z", 32'(db0), 32'hFF);
    rn[0] = 1'b1; wn[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("both_ce", 32'(ce_cnt[0] - b_ce), 32'd0);
    check("both_we", 32'(we_cnt[0] - b_we), 32'd0);
    check("both_oe", 32'(oe_cnt[0] - b_oe), 32'd0);
    check("both_busy", 32'(busy_cnt[0] - b_busy), 32'd0);
    check("both_err", 32'(bif0.err), 32'd1);
    do_op(0, 1'b1, 7'h30, 8'h11, rdv, zv, we_c, oe_c, busy_c);
    check("err_sticky", 32'(bif0.err), 32'd1);
    check("after_err_sram", 32'(mem0[7'h30]), 32'h11);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("err_cleared", 32'(bif0.err), 32'd0);
    repeat (3) @(negedge clk);

    // Reset during write ACCESS
    tb_addr = 7'h55; tb_data = 8'h3C; tb_drv = 1'b1; wn[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("midwr_we_low", 32'(bif0.sram_we_n), 32'd0);
    check("midwr_sd", 32'(sd0), 32'h3C);
    rst[0] = 1'b1;
    #1;
    check("midrst_we_n", 32'(bif0.sram_we_n), 32'd1);
    check("midrst_ce_n", 32'(bif0.sram_ce_n), 32'd1);
    check("midrst_sd_z", 32'(sd0), 32'hFF);
    check("midrst_busy", 32'(bif0.busy), 32'd0);
    wn[0] = 1'b1; tb_drv = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    do_op(0, 1'b1, 7'h55, 8'h96, rdv, zv, we_c, oe_c, busy_c);
    check("postrst_sram", 32'(mem0[7'h55]), 32'h96);
    check("postrst_we_len", 32'(we_c), 32'd2);
    check("postrst_busy_len", 32'(busy_c), 32'd4);

    // Back-to-back: second write lands while the first is in ACCESS
    base = commit_q.size();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bh[i] = busy_v[0];
      case (i)
        0:  begin tb_addr = 7'h01; tb_data = 8'h33; tb_drv = 1'b1; wn[0] = 1'b0; end
        2:  wn[0] = 1'b1;
        3:  begin tb_addr = 7'h02; tb_data = 8'h44; wn[0] = 1'b0; end
        10: begin wn[0] = 1'b1; tb_drv = 1'b0; end
        default: ;
      endcase
    end
    n_hi = 0; runs = 0; gap = -1; last_hi = -1;
    for (int i = 0; i < 16; i++) begin
      if (bh[i]) begin
        n_hi++;
        if (i == 0 || !bh[i-1]) begin
          runs++;
          if (last_hi >= 0) gap = i - last_hi - 1;
        end
        last_hi = i;
      end
    end
    check("b2b_busy_total", 32'(n_hi), 32'd8);
    check("b2b_runs", 32'(runs), 32'd2);
    check("b2b_idle_gap", 32'(gap), 32'd1);
    check("b2b_commits", 32'(commit_q.size() - base), 32'd2);
    if (commit_q.size() - base >= 2) begin
      check("b2b_first", 32'(commit_q[base]), 32'h01);
      check("b2b_second", 32'(commit_q[base + 1]), 32'h02);
    end
    check("b2b_mem1", 32'(mem0[7'h01]), 32'h33);
    check("b2b_mem2", 32'(mem0[7'h02]), 32'h44);
    repeat (3) @(negedge clk);

    // Minimum wait on the WAIT_CYCLES=1 instance
    do_op(1, 1'b1, 7'h7E, 8'h81, rdv, zv, we_c, oe_c, busy_c);
    check("w1_wr7e_we_len", 32'(we_c), 32'd1);
    do_op(1, 1'b0, 7'h7E, 8'h00, rdv, zv, we_c, oe_c, busy_c);
    check("w1_rd7e", 32'(rdv), 32'h81);
    do_op(1, 1'b1, 7'h7F, 8'hFF, rdv, zv, we_c, oe_c, busy_c);
    check("w1_wr_we_len", 32'(we_c), 32'd1);
    check("w1_wr_busy_len", 32'(busy_c), 32'd3);
    check("w1_sram", 32'(mem1[7'h7F]), 32'hFF);
    do_op(1, 1'b0, 7'h7F, 8'h00, rdv, zv, we_c, oe_c, busy_c);
    check("w1_rd", 32'(rdv), 32'hFF);
    check("w1_oe_len", 32'(oe_c), 32'd1);
    check("w1_rd_busy_len", 32'(busy_c), 32'd3);
    check("w1_db_z", 32'(zv), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d checks failed so far", n_fail, n_tests);
    $fatal(1, "watchdog");
  end

endmodule
